seq_comparator: RTL

- Parametrised, multi-cycle magnitude comparator and the wide successor of the team's 3-bit cascadable comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per clock, starting from the MSB slice.
- Honours the l/e/g cascade inputs when the operands are fully equal, and supports signed or unsigned compare.
- Sits between datapath registers and control logic that uses a start/done handshake.

---
 rtl/seq_comparator_pkg.sv | 26 ++
 rtl/seq_comparator_chunk.sv | 24 ++
 rtl/seq_comparator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_comparator_pkg.sv
// Shared types and sizing helpers for the sequential slice comparator.
// Used by seq_comparator (optional SEQ_COMPARATOR_EARLY_EXIT_EN build) and comparator_chunk.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SL_EQ = 2'b00,
    SL_LT = 2'b01,
    SL_GT = 2'b10
  } slice_res_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // The slice index counter keeps at least one bit, even for a single slice.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_comparator_chunk.sv
// Combinational magnitude compare of one CHUNK-bit slice (unsigned).
// The sign handling is done upstream, so every slice compares plain binary.
module comparator_chunk
  import seq_comparator_pkg::*;
#(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output slice_res_t       res
);

  always_comb begin
    // NOTE: every branch assigns res, so no latch can be inferred.
    if (a > b) begin
      res = SL_GT;
    end else if (a < b) begin
      res = SL_LT;
    end else begin
      res = SL_EQ;
    end
  end

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator with l/e/g cascade and start/done handshake.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish at the first differing slice.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int CHUNK  = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             lt,
  output logic             et,
  output logic             gt,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);

  // Flipping the top bit of both operands turns two's complement into offset binary.
  localparam logic [WIDTH-1:0] SIGN_FLIP = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       cas_q;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  slice_res_t       sl_res;
  slice_res_t       final_res;
  logic             finish;
  logic             accept;

`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
  logic             decided;
  slice_res_t       first_res;
`endif

  assign accept = (state == IDLE) && start;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign a_sl = a_q[idx*CHUNK +: CHUNK];
  assign b_sl = b_q[idx*CHUNK +: CHUNK];

  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a   (a_sl),
    .b   (b_sl),
    .res (sl_res)
  );

  always_comb begin
    final_res = sl_res;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    finish = (sl_res != SL_EQ) || (idx == '0);
`else
    finish = (idx == '0);
    if (decided) begin
      final_res = first_res;
    end
`endif
  end

  // NOTE: operand and cascade holders have no reset; they are loaded on accept before any use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= A ^ SIGN_FLIP;
      b_q   <= B ^ SIGN_FLIP;
      cas_q <= {l, e, g};
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      lt    <= 1'b0;
      et    <= 1'b0;
      gt    <= 1'b0;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
      decided   <= 1'b0;
      first_res <= SL_EQ;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            idx          <= IDX_W'(NCHUNK - 1);
            {lt, et, gt} <= 3'b000;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
            decided      <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
          // Only the most significant difference counts; later slices are ignored.
          if (!decided && sl_res != SL_EQ) begin
            decided   <= 1'b1;
            first_res <= sl_res;
          end
`endif
          if (finish) begin
            state <= DONE;
            case (final_res)
              SL_LT:   {lt, et, gt} <= 3'b100;
              SL_GT:   {lt, et, gt} <= 3'b001;
              default: {lt, et, gt} <= cas_q;
            endcase
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
